// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access-size encodings
// (same codes as data_mem dm_func), the arbiter state enum and the
// alignment rule.
package dmem_arbiter_pkg;

    localparam logic [2:0] FUNC_WORD  = 3'b000;
    localparam logic [2:0] FUNC_HALF  = 3'b001;
    localparam logic [2:0] FUNC_BYTE  = 3'b010;
    localparam logic [2:0] FUNC_HALFU = 3'b101;
    localparam logic [2:0] FUNC_BYTEU = 3'b110;

    typedef enum logic {
        S_CORE = 1'b0,
        S_LOCK = 1'b1
    } arb_state_t;

    // Unused codes (011/100/111) are full-word accesses, so they need 4-byte alignment.
    function automatic logic is_misaligned(input logic [2:0] func, input logic [1:0] addr_lo);
        case (func)
            FUNC_BYTE, FUNC_BYTEU: return 1'b0;
            FUNC_HALF, FUNC_HALFU: return addr_lo[0];
            default:               return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_align_chk.sv
// Flags an access whose byte address is not aligned to its access size.
module dmem_align_chk
    import dmem_arbiter_pkg::*;
(
    input  logic [2:0] func,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);

    assign misaligned = is_misaligned(func, addr_lo);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core load/store unit
// and the debug/loader port. The core normally wins; debug is forced a slot
// after MAX_WAIT denied cycles and may hold the memory with locked bursts,
// during which the core is forced one slot every LOCK_MAX debug grants.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_func,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic [31:0] core_rdata,
    output logic        core_err,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [2:0]  dbg_func,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic        dbg_lock,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic [2:0]  dm_func,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout,
    output logic [15:0] conflict_cnt
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    arb_state_t  state;
    logic [7:0]  wait_cnt;
    logic [7:0]  lock_cnt;
    logic        core_mis;
    logic        dbg_mis;
    logic        sel_core;
    logic        sel_dbg;

    dmem_align_chk u_core_align (
        .func       (core_func),
        .addr_lo    (core_addr[1:0]),
        .misaligned (core_mis)
    );

    dmem_align_chk u_dbg_align (
        .func       (dbg_func),
        .addr_lo    (dbg_addr[1:0]),
        .misaligned (dbg_mis)
    );

    // Grant decision; nothing is granted while reset is held so an aborted access never writes.
    always_comb begin
        sel_core = 1'b0;
        sel_dbg  = 1'b0;
        if (rst_n) begin
            if (state == S_CORE) begin
                if (dbg_req && (wait_cnt == MAX_WAIT_C)) begin
                    sel_dbg = 1'b1;
                end else if (core_req) begin
                    sel_core = 1'b1;
                end else if (dbg_req) begin
                    sel_dbg = 1'b1;
                end
            end else begin
                if (core_req && (lock_cnt == LOCK_MAX_C)) begin
                    sel_core = 1'b1;
                end else if (dbg_req) begin
                    sel_dbg = 1'b1;
                end
            end
        end
    end

    // Route the granted port to memory (core fields when idle) and return results to it only.
    always_comb begin
        if (sel_dbg) begin
            dm_func = dbg_func;
            dm_addr = dbg_addr;
            dm_din  = dbg_wdata;
        end else begin
            dm_func = core_func;
            dm_addr = core_addr;
            dm_din  = core_wdata;
        end
        dm_we      = (sel_core && core_we && !core_mis) || (sel_dbg && dbg_we && !dbg_mis);
        core_gnt   = sel_core;
        dbg_gnt    = sel_dbg;
        core_err   = sel_core && core_mis;
        dbg_err    = sel_dbg && dbg_mis;
        core_rdata = sel_core ? dm_dout : 32'h0;
        dbg_rdata  = sel_dbg ? dm_dout : 32'h0;
    end

    // Ownership state, debug starvation/burst counters and the conflict statistic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_CORE;
            wait_cnt     <= 8'd0;
            lock_cnt     <= 8'd0;
            conflict_cnt <= 16'd0;
        end else begin
            if (core_req && dbg_req && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end

            if (dbg_req && !sel_dbg) begin
                if (wait_cnt != MAX_WAIT_C) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end else begin
                wait_cnt <= 8'd0;
            end

            case (state)
                S_CORE: begin
                    if (sel_dbg && dbg_lock) begin
                        state    <= S_LOCK;
                        lock_cnt <= 8'd1;
                    end
                end
                S_LOCK: begin
                    // Saturate at LOCK_MAX so a late core request still gets its slot.
                    if (sel_core) begin
                        lock_cnt <= 8'd0;
                    end else if (sel_dbg && (lock_cnt != LOCK_MAX_C)) begin
                        lock_cnt <= lock_cnt + 8'd1;
                    end
                    if (!dbg_lock) begin
                        state    <= S_CORE;
                        lock_cnt <= 8'd0;
                    end
                end
                default: begin
                    state    <= S_CORE;
                    lock_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 8;
    localparam int LOCK_MAX = 16;

    localparam logic [2:0] F_W  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_B  = 3'b010;
    localparam logic [2:0] F_HU = 3'b101;
    localparam logic [2:0] F_BU = 3'b110;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        core_req, core_we, core_gnt, core_err;
    logic [2:0]  core_func;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_err;
    logic [2:0]  dbg_func;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [2:0]  dm_func;
    logic        dm_we;
    logic [31:0] dm_addr, dm_din, dm_dout;
    logic [15:0] conflict_cnt;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_func(core_func), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rdata(core_rdata), .core_err(core_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_func(dbg_func), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
        .dbg_err(dbg_err), .dm_func(dm_func), .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_dout(dm_dout), .conflict_cnt(conflict_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- data memory (environment) and shadow memory ----------------
    logic [7:0] mem  [256];
    logic [7:0] smem [256];
    logic       mem_clr;

    function automatic int acc_size(input logic [2:0] f);
        if (f == F_B || f == F_BU) return 1;
        if (f == F_H || f == F_HU) return 2;
        return 4;
    endfunction

    function automatic bit misal(input logic [2:0] f, input logic [31:0] a);
        return (int'(a[7:0]) % acc_size(f)) != 0;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] lo, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f)
            F_H:     return {{16{h[15]}}, h};
            F_HU:    return {16'h0, h};
            F_B:     return {{24{b[7]}}, b};
            F_BU:    return {24'h0, b};
            default: return w;
        endcase
    endfunction

    logic [7:0] ra;
    assign ra = {dm_addr[7:2], 2'b00};
    assign dm_dout = extract(dm_func, dm_addr[1:0],
                             {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]});

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
        end else if (dm_we) begin
            for (int k = 0; k < acc_size(dm_func); k++) mem[dm_addr[7:0] + 8'(k)] <= dm_din[8*k +: 8];
        end
    end

    function automatic logic [31:0] shadow_read(input logic [2:0] f, input logic [31:0] a);
        int base;
        base = int'(a[7:0]) & ~3;
        return extract(f, a[1:0], {smem[base+3], smem[base+2], smem[base+1], smem[base]});
    endfunction

    function automatic logic [31:0] env_word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic shadow_write(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < acc_size(f); k++) smem[(int'(a[7:0]) + k) % 256] = d[8*k +: 8];
    endtask

    // ---------------- behavioural arbitration model ----------------
    bit m_locked;      // debug currently owns the memory through a locked burst
    int m_denied;      // consecutive cycles debug asked and was refused
    int m_burst;       // debug grants since burst start or last forced core slot
    int m_conf;        // cycles with both ports requesting
    bit e_core, e_dbg; // expected grants for the current cycle

    task automatic model_reset();
        m_locked = 0; m_denied = 0; m_burst = 0; m_conf = 0;
    endtask

    task automatic model_eval();
        e_core = 0; e_dbg = 0;
        if (!m_locked) begin
            if (dbg_req && m_denied >= MAX_WAIT) e_dbg = 1;
            else if (core_req)                  e_core = 1;
            else if (dbg_req)                   e_dbg = 1;
        end else begin
            if (core_req && m_burst >= LOCK_MAX) e_core = 1;
            else if (dbg_req)                    e_dbg = 1;
        end
    endtask

    task automatic model_commit();
        if (core_req && dbg_req && m_conf < 65535) m_conf++;
        if (dbg_req && !e_dbg) m_denied++;
        else m_denied = 0;
        if (!m_locked) begin
            if (e_dbg && dbg_lock) begin m_locked = 1; m_burst = 1; end
        end else begin
            if (e_core) m_burst = 0;
            else if (e_dbg) m_burst++;
            if (!dbg_lock) begin m_locked = 0; m_burst = 0; end
        end
        if (e_core && core_we && !misal(core_func, core_addr)) shadow_write(core_func, core_addr, core_wdata);
        if (e_dbg && dbg_we && !misal(dbg_func, dbg_addr)) shadow_write(dbg_func, dbg_addr, dbg_wdata);
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        core_req = 0; core_we = 0; core_func = F_W; core_addr = 0; core_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_func = F_W; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        core_req = 1; core_we = 1; core_func = F_W; core_addr = 32'h10; core_wdata = 32'hA5A5_0001;
        dbg_req = 1; dbg_we = 1; dbg_func = F_W; dbg_addr = 32'h20; dbg_wdata = 32'h5A5A_0002;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({core_gnt, dbg_gnt, dm_we, core_err, dbg_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b required 00000", {core_gnt, dbg_gnt, dm_we, core_err, dbg_err});
        end
        n_tests++;
        if (conflict_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_conflict: got %0d required 0", conflict_cnt);
        end
        rst_n = 1;
        model_reset();
        #1;
        n_tests++;
        if ({core_gnt, dbg_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL reset_first_gnt: got %b required 10", {core_gnt, dbg_gnt});
        end
        step();
        n_tests++;
        if (conflict_cnt !== 16'd1) begin
            n_fail++; $display("FAIL reset_conflict_start: got %0d required 1", conflict_cnt);
        end
        idle();
        step();
    endtask

    task automatic test_store_load();
        core_req = 1; core_we = 1; core_func = F_W; core_addr = 32'h40; core_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++;
        if ({core_gnt, dm_we, dm_addr} !== {2'b11, 32'h40}) begin
            n_fail++; $display("FAIL store_word: got gnt/we %b addr %h required 11 / 40", {core_gnt, dm_we}, dm_addr);
        end
        step();
        idle();
        dbg_req = 1; dbg_we = 0; dbg_func = F_BU; dbg_addr = 32'h43;
        @(negedge clk);
        n_tests++;
        if (dbg_gnt !== 1'b1 || dbg_rdata !== 32'h0000_00DE) begin
            n_fail++; $display("FAIL load_byteu: got gnt %b rdata %h required 1 / 000000de", dbg_gnt, dbg_rdata);
        end
        n_tests++;
        if (core_rdata !== 32'h0 || core_gnt !== 1'b0) begin
            n_fail++; $display("FAIL idle_port_zero: got gnt %b rdata %h required 0 / 0", core_gnt, core_rdata);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_starvation();
        core_req = 1; core_we = 0; core_func = F_W; core_addr = 32'h40;
        dbg_req = 1; dbg_we = 0; dbg_func = F_W; dbg_addr = 32'h44; dbg_lock = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            n_tests++;
            if ({core_gnt, dbg_gnt} !== ((c == MAX_WAIT + 1) ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL starve_cycle%0d: got %b required %b", c, {core_gnt, dbg_gnt},
                                   (c == MAX_WAIT + 1) ? 2'b01 : 2'b10);
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_lock_burst();
        int  k;
        bit  ok;
        k = 0;
        for (int c = 1; c <= 21; c++) begin
            dbg_req = 1; dbg_we = 1; dbg_func = F_W; dbg_addr = 32'h80 + 32'(4 * k);
            dbg_wdata = $urandom; dbg_lock = (k < 19);
            core_req = (c > 1); core_we = 0; core_func = F_W; core_addr = 32'h40;
            @(negedge clk);
            n_tests++;
            if ({core_gnt, dbg_gnt} !== ((c == LOCK_MAX + 1) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL burst_cycle%0d: got %b required %b", c, {core_gnt, dbg_gnt},
                                   (c == LOCK_MAX + 1) ? 2'b10 : 2'b01);
            end
            step();
            if (c != LOCK_MAX + 1) k++;
        end
        dbg_req = 0; dbg_we = 0; dbg_lock = 0;
        @(negedge clk);
        n_tests++;
        if (core_gnt !== 1'b1) begin
            n_fail++; $display("FAIL burst_exit: got core_gnt %b required 1", core_gnt);
        end
        step();
        ok = 1;
        for (int i = 32'h80; i < 32'hD0; i++) if (mem[i] !== smem[i]) ok = 0;
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL burst_data: got word80 %h required %h", env_word(32'h80), shadow_read(F_W, 32'h80));
        end
        idle();
        step();
    endtask

    task automatic test_misaligned();
        core_req = 1; core_we = 1; core_func = F_H; core_addr = 32'h41; core_wdata = 32'h0000_1234;
        @(negedge clk);
        n_tests++;
        if ({core_gnt, core_err, dm_we} !== 3'b110) begin
            n_fail++; $display("FAIL misaligned_half: got gnt/err/we %b required 110", {core_gnt, core_err, dm_we});
        end
        step();
        core_we = 0; core_func = F_W; core_addr = 32'h40;
        @(negedge clk);
        n_tests++;
        if (core_rdata !== 32'hDEAD_BEEF || core_err !== 1'b0) begin
            n_fail++; $display("FAIL misaligned_readback: got %h err %b required deadbeef / 0", core_rdata, core_err);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_reset_in_burst();
        logic [31:0] old_c4;
        dbg_req = 1; dbg_we = 1; dbg_func = F_W; dbg_addr = 32'hC0; dbg_wdata = 32'h1111_1111; dbg_lock = 1;
        @(negedge clk);
        n_tests++;
        if (dbg_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rstburst_first: got dbg_gnt %b required 1", dbg_gnt);
        end
        step();
        old_c4 = shadow_read(F_W, 32'hC4);
        dbg_addr = 32'hC4; dbg_wdata = 32'h55AA_55AA;
        core_req = 1; core_we = 0; core_func = F_W; core_addr = 32'h40;
        @(negedge clk);
        n_tests++;
        if ({core_gnt, dbg_gnt, dm_we} !== 3'b011) begin
            n_fail++; $display("FAIL rstburst_locked: got %b required 011", {core_gnt, dbg_gnt, dm_we});
        end
        rst_n = 0;
        #1;
        n_tests++;
        if ({dbg_gnt, dm_we} !== 2'b00) begin
            n_fail++; $display("FAIL rstburst_abort: got gnt/we %b required 00", {dbg_gnt, dm_we});
        end
        @(posedge clk);
        model_reset();
        #1;
        dbg_req = 0; dbg_we = 0; dbg_lock = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        n_tests++;
        if (core_gnt !== 1'b1 || core_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rstburst_state: got gnt %b rdata %h required 1 / deadbeef", core_gnt, core_rdata);
        end
        n_tests++;
        if (conflict_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rstburst_conflict: got %0d required 0", conflict_cnt);
        end
        n_tests++;
        if (env_word(32'hC4) !== old_c4 || env_word(32'hC0) !== 32'h1111_1111) begin
            n_fail++; $display("FAIL rstburst_nowrite: got c0 %h c4 %h required 11111111 / %h",
                               env_word(32'hC0), env_word(32'hC4), old_c4);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit          exp_we;
        for (int c = 0; c < 600; c++) begin
            core_req   = ($urandom_range(0, 99) < 55);
            core_we    = $urandom_range(0, 1) == 1;
            core_func  = 3'($urandom_range(0, 7));
            a          = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(core_func) - 1);
            core_addr  = a;
            core_wdata = $urandom;
            dbg_req    = ($urandom_range(0, 99) < (m_locked ? 85 : 50));
            dbg_we     = $urandom_range(0, 1) == 1;
            dbg_func   = 3'($urandom_range(0, 7));
            a          = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(dbg_func) - 1);
            dbg_addr   = a;
            dbg_wdata  = $urandom;
            dbg_lock   = ($urandom_range(0, 99) < (m_locked ? 93 : 15));
            @(negedge clk);
            model_eval();
            n_tests++;
            if ({core_gnt, dbg_gnt} !== {e_core, e_dbg}) begin
                n_fail++; $display("FAIL rnd_gnt c%0d: got %b required %b", c, {core_gnt, dbg_gnt}, {e_core, e_dbg});
            end
            exp_we = (e_core && core_we && !misal(core_func, core_addr)) ||
                     (e_dbg && dbg_we && !misal(dbg_func, dbg_addr));
            n_tests++;
            if (dm_we !== exp_we) begin
                n_fail++; $display("FAIL rnd_we c%0d: got %b required %b", c, dm_we, exp_we);
            end
            n_tests++;
            if ({core_err, dbg_err} !== {e_core && misal(core_func, core_addr), e_dbg && misal(dbg_func, dbg_addr)}) begin
                n_fail++; $display("FAIL rnd_err c%0d: got %b required %b", c, {core_err, dbg_err},
                                   {e_core && misal(core_func, core_addr), e_dbg && misal(dbg_func, dbg_addr)});
            end
            if (!e_core || (!core_we && !misal(core_func, core_addr))) begin
                n_tests++;
                if (core_rdata !== (e_core ? shadow_read(core_func, core_addr) : 32'h0)) begin
                    n_fail++; $display("FAIL rnd_core_rdata c%0d: got %h required %h", c, core_rdata,
                                       e_core ? shadow_read(core_func, core_addr) : 32'h0);
                end
            end
            if (!e_dbg || (!dbg_we && !misal(dbg_func, dbg_addr))) begin
                n_tests++;
                if (dbg_rdata !== (e_dbg ? shadow_read(dbg_func, dbg_addr) : 32'h0)) begin
                    n_fail++; $display("FAIL rnd_dbg_rdata c%0d: got %h required %h", c, dbg_rdata,
                                       e_dbg ? shadow_read(dbg_func, dbg_addr) : 32'h0);
                end
            end
            n_tests++;
            if (conflict_cnt !== 16'(m_conf)) begin
                n_fail++; $display("FAIL rnd_conflict c%0d: got %0d required %0d", c, conflict_cnt, m_conf);
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_final_memory();
        int bad;
        bad = -1;
        for (int i = 0; i < 256; i++) if (bad < 0 && mem[i] !== smem[i]) bad = i;
        n_tests++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL final_mem at %0d: got %h required %h", bad, mem[bad], smem[bad]);
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        mem_clr = 1;
        for (int i = 0; i < 256; i++) smem[i] = 8'(i * 37 + 5);
        model_reset();
        @(posedge clk);
        #1;
        mem_clr = 0;
        test_reset();
        test_store_load();
        test_starvation();
        test_lock_burst();
        test_misaligned();
        test_reset_in_burst();
        test_random();
        test_final_memory();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
